param_fifo: RTL and testbench

PARAM_FIFO -- requirements
Module: param_fifo

---
 rtl/param_fifo_pkg.sv | 14 +
 rtl/param_fifo_mem.sv | 27 ++
 rtl/param_fifo.sv | 121 ++++++++++++
 tb/tb_param_fifo.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/param_fifo_pkg.sv
// Shared defaults and helpers for the parameterised synchronous FIFO.
package param_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_AF_GAP     = 1;
  localparam int DEF_AE_GAP     = 1;

  // Occupancy must represent 0..DEPTH inclusive, hence one bit above the address width.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/param_fifo_mem.sv
// FIFO storage array: one synchronous write port, one asynchronous read port.
module param_fifo_mem
  import param_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Storage write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/param_fifo.sv
// Parameterised synchronous FIFO with occupancy flags and one-cycle status pulses.
// Define PARAM_FIFO_FWFT_EN for first-word fall-through output; default is registered read data.
module param_fifo
  import param_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int AF_GAP     = DEF_AF_GAP,
  parameter int AE_GAP     = DEF_AE_GAP
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          wr_en,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          wr_ack,
  output logic                          overflow,
  output logic                          underflow,
  output logic                          full,
  output logic                          empty,
  output logic                          almostfull,
  output logic                          almostempty,
  output logic [cnt_width(DEPTH)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(DEPTH - AF_GAP);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_GAP);

  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic [CW-1:0]         count_nxt_s;
  logic                  wr_ack_r;
  logic                  overflow_r;
  logic                  underflow_r;
  logic                  full_s;
  logic                  empty_s;
  logic                  do_wr_s;
  logic                  do_rd_s;
  logic [DATA_WIDTH-1:0] rd_data_s;

  assign full_s  = (count_r == FULL_CNT);
  assign empty_s = (count_r == {CW{1'b0}});
  // Full blocks only the write and empty only the read, so a collision degrades to one op.
  assign do_wr_s = wr_en & ~full_s;
  assign do_rd_s = rd_en & ~empty_s;

  param_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (do_wr_s),
    .wr_addr (wr_ptr_r),
    .wr_data (data_in),
    .rd_addr (rd_ptr_r),
    .rd_data (rd_data_s)
  );

  // Occupancy update: write-only increments, read-only decrements, otherwise hold.
  always_comb begin
    count_nxt_s = count_r;
    case ({do_wr_s, do_rd_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, occupancy and status-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {CW{1'b0}};
      wr_ack_r    <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      wr_ptr_r    <= do_wr_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
      rd_ptr_r    <= do_rd_s ? rd_ptr_r + AW'(1) : rd_ptr_r;
      count_r     <= count_nxt_s;
      wr_ack_r    <= do_wr_s;
      overflow_r  <= wr_en & full_s;
      underflow_r <= rd_en & empty_s;
    end
  end

`ifdef PARAM_FIFO_FWFT_EN
  assign data_out = empty_s ? {DATA_WIDTH{1'b0}} : rd_data_s;
`else
  logic [DATA_WIDTH-1:0] data_out_r;

  // Registered read data, captured only on an accepted read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_r <= {DATA_WIDTH{1'b0}};
    end else if (do_rd_s) begin
      data_out_r <= rd_data_s;
    end else begin
      data_out_r <= data_out_r;
    end
  end

  assign data_out = data_out_r;
`endif

  assign wr_ack      = wr_ack_r;
  assign overflow    = overflow_r;
  assign underflow   = underflow_r;
  assign full        = full_s;
  assign empty       = empty_s;
  assign almostfull  = (count_r >= AF_CNT) & ~full_s;
  assign almostempty = (count_r <= AE_CNT) & ~empty_s;
  assign count       = count_r;

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo against a queue-based reference model.
// Honours PARAM_FIFO_FWFT_EN to select the expected read-data behaviour.
module tb_param_fifo;

  localparam int DW = 16;
  localparam int DEPTH = 8;
  localparam int AF_GAP = 1;
  localparam int AE_GAP = 1;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] data_in;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] data_out;
  logic          wr_ack, overflow, underflow;
  logic          full, empty, almostfull, almostempty;
  logic [3:0]    count;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] exp_dout;
  logic          exp_ack, exp_ovf, exp_udf;

  param_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .AF_GAP     (AF_GAP),
    .AE_GAP     (AE_GAP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .wr_ack      (wr_ack),
    .overflow    (overflow),
    .underflow   (underflow),
    .full        (full),
    .empty       (empty),
    .almostfull  (almostfull),
    .almostempty (almostempty),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    logic [DW-1:0] e_out;
    n = q.size();
`ifdef PARAM_FIFO_FWFT_EN
    e_out = (n > 0) ? q[0] : 16'h0000;
`else
    e_out = exp_dout;
`endif
    chk({tag, ".count"},       16'(count),       16'(n));
    chk({tag, ".full"},        16'(full),        16'(n == DEPTH));
    chk({tag, ".empty"},       16'(empty),       16'(n == 0));
    chk({tag, ".almostfull"},  16'(almostfull),  16'((n >= DEPTH - AF_GAP) && (n != DEPTH)));
    chk({tag, ".almostempty"}, 16'(almostempty), 16'((n <= AE_GAP) && (n != 0)));
    chk({tag, ".wr_ack"},      16'(wr_ack),      16'(exp_ack));
    chk({tag, ".overflow"},    16'(overflow),    16'(exp_ovf));
    chk({tag, ".underflow"},   16'(underflow),   16'(exp_udf));
    chk({tag, ".data_out"},    data_out,         e_out);
  endtask

  // One clock: drive at the falling edge, apply the model, check at the next falling edge.
  task automatic cycle(input string tag, input logic w, input logic r, input logic [DW-1:0] d);
    logic is_full, is_empty;
    logic [DW-1:0] popped;
    wr_en = w;
    rd_en = r;
    data_in = d;
    is_full  = (q.size() == DEPTH);
    is_empty = (q.size() == 0);
    exp_ack = w && !is_full;
    exp_ovf = w && is_full;
    exp_udf = r && is_empty;
    if (r && !is_empty) begin
      popped = q.pop_front();
      exp_dout = popped;
    end
    if (w && !is_full) q.push_back(d);
    @(posedge clk);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst_n = 1'b0;
    #1;
    q.delete();
    exp_dout = 16'h0000;
    exp_ack = 1'b0;
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    check_all({tag, ".asserted"});
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all({tag, ".released"});
    @(negedge clk);
  endtask

  task automatic random_phase(input int cycles, input int wr_pct, input int rd_pct);
    for (int i = 0; i < cycles; i++) begin
      cycle("rand", ($urandom_range(0, 99) < wr_pct), ($urandom_range(0, 99) < rd_pct),
            DW'($urandom));
    end
  endtask

  initial begin
    rst_n = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    data_in = 16'h0000;
    exp_dout = 16'h0000;
    exp_ack = 1'b0;
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
    @(negedge clk);
    do_reset("reset0");

    for (int i = 1; i <= DEPTH; i++) cycle("fill", 1'b1, 1'b0, DW'(i));
    cycle("wr_full", 1'b1, 1'b0, 16'hDEAD);
    cycle("wr_full_rd", 1'b1, 1'b1, 16'hDEAD);
    cycle("refill", 1'b1, 1'b0, 16'h0009);
    for (int i = 0; i < DEPTH; i++) cycle("drain", 1'b0, 1'b1, 16'h0000);
    cycle("rd_empty", 1'b0, 1'b1, 16'h0000);
    cycle("rd_empty_wr", 1'b1, 1'b1, 16'h1234);
    cycle("drain1", 1'b0, 1'b1, 16'h0000);

    for (int i = 0; i < 4; i++) cycle("pre4", 1'b1, 1'b0, DW'($urandom));
    for (int i = 0; i < 20; i++) cycle("stream", 1'b1, 1'b1, DW'($urandom));
    for (int i = 0; i < 4; i++) cycle("post4", 1'b0, 1'b1, 16'h0000);

    random_phase(150, 70, 30);
    random_phase(150, 30, 70);
    random_phase(150, 50, 50);

    while (q.size() < 5) cycle("to5", 1'b1, 1'b0, DW'($urandom));
    while (q.size() > 5) cycle("to5", 1'b0, 1'b1, 16'h0000);
    do_reset("reset_mid");
    cycle("rd_after_rst", 1'b0, 1'b1, 16'h0000);

    cycle("single_wr", 1'b1, 1'b0, 16'h00A5);
    cycle("idle", 1'b0, 1'b0, 16'h0000);
    cycle("pop_a5", 1'b0, 1'b1, 16'h0000);
    random_phase(100, 60, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
